mc_cu: RTL

- Multi-cycle control unit: sequences one shared ALU, a single unified memory and the register file through IF/ID/EXE/MEM/WB.
- Decodes the same MIPS subset as the single-cycle CPU: add sub and or xor sll srl sra jr addi andi ori xori lw sw beq bne lui j jal.
- Sits between the instruction register (op, func) / ALU zero flag and the multi-cycle datapath mux selects and write enables.

---
 rtl/mc_cu.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_cu.sv
`default_nettype none
// ============================================================================
// Module   : mc_cu
// Brief    : Multi-cycle MIPS-subset control unit. Steps one instruction
//            through IF/ID/EXE/MEM/WB and drives the shared ALU, unified
//            memory and register-file selects and write enables.
//            Optional macro MC_CU_MEMWAIT_EN: IF and MEM stall on mem_ready.
// Revision : 1.0 - initial release
// ============================================================================
module mc_cu #(
  parameter int ST_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [5:0]      op,
  input  logic [5:0]      func,
  input  logic            z,
  input  logic            mem_ready,
  output logic            wpc,
  output logic            wir,
  output logic            wmem,
  output logic            wreg,
  output logic            iord,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsource,
  output logic [3:0]      aluc,
  output logic            shift,
  output logic            sext,
  output logic            regrt,
  output logic            m2reg,
  output logic            jal,
  output logic            instr_done,
  output logic [ST_W-1:0] state
);

  localparam logic [3:0] C_ALU_ADD = 4'b0000;
  localparam logic [3:0] C_ALU_SUB = 4'b0100;
  localparam logic [3:0] C_ALU_AND = 4'b0001;
  localparam logic [3:0] C_ALU_OR  = 4'b0101;
  localparam logic [3:0] C_ALU_XOR = 4'b0010;
  localparam logic [3:0] C_ALU_LUI = 4'b0110;
  localparam logic [3:0] C_ALU_SLL = 4'b0011;
  localparam logic [3:0] C_ALU_SRL = 4'b0111;
  localparam logic [3:0] C_ALU_SRA = 4'b1111;

  typedef enum logic [ST_W-1:0] {
    S_IF  = ST_W'(0),
    S_ID  = ST_W'(1),
    S_EXE = ST_W'(2),
    S_MEM = ST_W'(3),
    S_WB  = ST_W'(4)
  } state_e;

  state_e state_q, state_d;

  // Instruction decode (op/func come straight from the instruction register)
  logic w_rtype, w_add, w_sub, w_and, w_or, w_xor, w_sll, w_srl, w_sra, w_jr;
  logic w_addi, w_andi, w_ori, w_xori, w_lui, w_lw, w_sw, w_beq, w_bne, w_j, w_jal;
  logic w_r_alu, w_i_alu, w_shift_op, w_taken;

  assign w_rtype    = (op == 6'b000000);
  assign w_add      = w_rtype & (func == 6'b100000);
  assign w_sub      = w_rtype & (func == 6'b100010);
  assign w_and      = w_rtype & (func == 6'b100100);
  assign w_or       = w_rtype & (func == 6'b100101);
  assign w_xor      = w_rtype & (func == 6'b100110);
  assign w_sll      = w_rtype & (func == 6'b000000);
  assign w_srl      = w_rtype & (func == 6'b000010);
  assign w_sra      = w_rtype & (func == 6'b000011);
  assign w_jr       = w_rtype & (func == 6'b001000);
  assign w_addi     = (op == 6'b001000);
  assign w_andi     = (op == 6'b001100);
  assign w_ori      = (op == 6'b001101);
  assign w_xori     = (op == 6'b001110);
  assign w_lui      = (op == 6'b001111);
  assign w_lw       = (op == 6'b100011);
  assign w_sw       = (op == 6'b101011);
  assign w_beq      = (op == 6'b000100);
  assign w_bne      = (op == 6'b000101);
  assign w_j        = (op == 6'b000010);
  assign w_jal      = (op == 6'b000011);
  assign w_shift_op = w_sll | w_srl | w_sra;
  assign w_r_alu    = w_add | w_sub | w_and | w_or | w_xor | w_shift_op;
  assign w_i_alu    = w_addi | w_andi | w_ori | w_xori | w_lui;
  assign w_taken    = (w_beq & z) | (w_bne & ~z);

`ifndef MC_CU_MEMWAIT_EN
  // Single-cycle memory: the handshake input has no effect in this build
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
`endif

  // State register; reset returns to IF and abandons any instruction in flight
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next-state and datapath controls; write enables masked while in reset
  always_comb begin
    state_d    = S_IF;
    wpc        = 1'b0;
    wir        = 1'b0;
    wmem       = 1'b0;
    wreg       = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsource   = 2'b00;
    aluc       = C_ALU_ADD;
    shift      = 1'b0;
    sext       = 1'b0;
    regrt      = 1'b0;
    m2reg      = 1'b0;
    jal        = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_IF: begin
        alusrcb = 2'b01;
`ifdef MC_CU_MEMWAIT_EN
        if (mem_ready) begin
          wir     = 1'b1;
          wpc     = 1'b1;
          state_d = S_ID;
        end else begin
          state_d = S_IF;
        end
`else
        wir     = 1'b1;
        wpc     = 1'b1;
        state_d = S_ID;
`endif
      end
      S_ID: begin
        // ALU precomputes the branch target while the instruction decodes
        alusrcb = 2'b11;
        if (w_j | w_jal) begin
          wpc        = 1'b1;
          pcsource   = 2'b11;
          wreg       = w_jal;
          jal        = w_jal;
          instr_done = 1'b1;
        end else if (w_jr) begin
          wpc        = 1'b1;
          pcsource   = 2'b10;
          instr_done = 1'b1;
        end else if (w_r_alu | w_i_alu | w_lw | w_sw | w_beq | w_bne) begin
          state_d = S_EXE;
        end else begin
          instr_done = 1'b1;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        if (w_r_alu) begin
          shift   = w_shift_op;
          state_d = S_WB;
          if      (w_sub) aluc = C_ALU_SUB;
          else if (w_and) aluc = C_ALU_AND;
          else if (w_or)  aluc = C_ALU_OR;
          else if (w_xor) aluc = C_ALU_XOR;
          else if (w_sll) aluc = C_ALU_SLL;
          else if (w_srl) aluc = C_ALU_SRL;
          else if (w_sra) aluc = C_ALU_SRA;
        end else if (w_i_alu) begin
          alusrcb = 2'b10;
          sext    = w_addi;
          state_d = S_WB;
          if      (w_andi) aluc = C_ALU_AND;
          else if (w_ori)  aluc = C_ALU_OR;
          else if (w_xori) aluc = C_ALU_XOR;
          else if (w_lui)  aluc = C_ALU_LUI;
        end else if (w_lw | w_sw) begin
          alusrcb = 2'b10;
          sext    = 1'b1;
          state_d = S_MEM;
        end else if (w_beq | w_bne) begin
          aluc       = C_ALU_SUB;
          wpc        = w_taken;
          pcsource   = w_taken ? 2'b01 : 2'b00;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (w_sw) begin
          wmem = 1'b1;
`ifdef MC_CU_MEMWAIT_EN
          instr_done = mem_ready;
          state_d    = mem_ready ? S_IF : S_MEM;
`else
          instr_done = 1'b1;
`endif
        end else if (w_lw) begin
`ifdef MC_CU_MEMWAIT_EN
          state_d = mem_ready ? S_WB : S_MEM;
`else
          state_d = S_WB;
`endif
        end
      end
      S_WB: begin
        wreg       = 1'b1;
        regrt      = ~w_rtype;
        m2reg      = w_lw;
        instr_done = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    if (reset) begin
      wpc        = 1'b0;
      wir        = 1'b0;
      wmem       = 1'b0;
      wreg       = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire
